// File: rtl/shift_request_sequencer_if.sv
// Bundle of the requester, shifter and response signals around
// shift_request_sequencer. The sequencer takes the slave view; the
// requesters, the shifter datapath and the response consumer together
// form the master side.
interface shift_request_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int SETS  = 2,
   parameter int N_REQ = 4,
   parameter int AMT_W = 4,
   parameter int ID_W  = 2
);

   logic [N_REQ-1:0]            req;
   logic [N_REQ*SETS*WIDTH-1:0] req_data;
   logic [N_REQ*AMT_W-1:0]      req_amt;
   logic [N_REQ-1:0]            req_dir;
   logic [N_REQ-1:0]            req_fill;
   logic [N_REQ-1:0]            gnt;

   logic [SETS*WIDTH-1:0]       sh_in_packed;
   logic [SETS*WIDTH-1:0]       sh_shift_packed;
   logic [SETS*WIDTH-1:0]       sh_out_packed;
   logic [SETS*WIDTH-1:0]       sh_overflow_packed;

   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [ID_W-1:0]             rsp_id;
   logic [SETS*WIDTH-1:0]       rsp_data;
   logic [SETS*WIDTH-1:0]       rsp_overflow;
   logic                        busy;

   modport master (
      output req, req_data, req_amt, req_dir, req_fill,
      output sh_out_packed, sh_overflow_packed, rsp_ready,
      input  gnt, sh_in_packed, sh_shift_packed,
      input  rsp_valid, rsp_id, rsp_data, rsp_overflow, busy
   );

   modport slave (
      input  req, req_data, req_amt, req_dir, req_fill,
      input  sh_out_packed, sh_overflow_packed, rsp_ready,
      output gnt, sh_in_packed, sh_shift_packed,
      output rsp_valid, rsp_id, rsp_data, rsp_overflow, busy
   );

endinterface

// File: rtl/shift_request_sequencer.sv
// shift_request_sequencer: shares one combinational shifter among N_REQ
// requesters. Round-robin arbitration picks a requester, large shift amounts
// are split into several shifter passes, and the result is returned over a
// valid/ready handshake.
// Optional feature: define SHIFT_SEQ_STATS_EN to add the ops_done counter
// of completed response transfers.
module shift_request_sequencer #(
   parameter int WIDTH = 4,
   parameter int SETS  = 2,
   parameter int N_REQ = 4,
   parameter int AMT_W = 4,
   parameter int ID_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   shift_request_sequencer_if.slave bus
`ifdef SHIFT_SEQ_STATS_EN
   ,
   output logic [15:0]             ops_done
`endif
);

   localparam int DW     = SETS * WIDTH;
   localparam int LIMIT  = (2 ** (WIDTH - 2)) - 1;
   localparam int STEP0  = ((WIDTH - 1) < LIMIT) ? (WIDTH - 1) : LIMIT;
   localparam int STEP1  = ((WIDTH / 2) < LIMIT) ? (WIDTH / 2) : LIMIT;
   localparam logic [AMT_W-1:0] STEP0_A = AMT_W'(STEP0);
   localparam logic [AMT_W-1:0] STEP1_A = AMT_W'(STEP1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [ID_W-1:0]  ptr_q;
   logic [ID_W-1:0]  id_q;
   logic [DW-1:0]    work_q;
   logic [DW-1:0]    ovf_q;
   logic [AMT_W-1:0] rem_q;
   logic             dir_q;
   logic             fill_q;

   logic             anyReq;
   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  ptr_d;
   logic             grantEn;
   logic [DW-1:0]    capData;
   logic [AMT_W-1:0] capAmt;
   logic             capDir;
   logic             capFill;
   logic [AMT_W-1:0] stepMax;
   logic [AMT_W-1:0] step;
   logic [AMT_W-1:0] rem_d;
   logic [WIDTH-1:0] shWord;

   // Round-robin search: first pending request at or above the pointer, wrapping around
   always_comb begin
      anyReq = 1'b0;
      winner = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!anyReq && bus.req[(int'(ptr_q) + i) % N_REQ]) begin
            anyReq = 1'b1;
            winner = ID_W'((int'(ptr_q) + i) % N_REQ);
         end
      end
   end

   // Grant strobe, operand capture selects and the pass size for the current shift pass
   always_comb begin
      grantEn  = (state_q == IDLE) && !rst && anyReq;
      bus.gnt  = grantEn ? (N_REQ'(1) << winner) : '0;
      ptr_d    = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
      capData  = bus.req_data[winner*DW +: DW];
      capAmt   = bus.req_amt[winner*AMT_W +: AMT_W];
      capDir   = bus.req_dir[winner];
      capFill  = bus.req_fill[winner];
      stepMax  = dir_q ? STEP1_A : STEP0_A;
      step     = (rem_q < stepMax) ? rem_q : stepMax;
      rem_d    = rem_q - step;
      shWord   = {fill_q, (WIDTH-2)'(step), dir_q};
   end

   // Shifter drive and response view, all decoded from registered state
   always_comb begin
      bus.sh_in_packed    = work_q;
      bus.sh_shift_packed = (state_q == SHIFT) ? {SETS{shWord}} : '0;
      bus.rsp_valid       = (state_q == DONE);
      bus.rsp_id          = id_q;
      bus.rsp_data        = work_q;
      bus.rsp_overflow    = ovf_q;
      bus.busy            = (state_q != IDLE);
   end

   // Sequencer FSM: accept a request, run the passes, hold the result until it is taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         work_q  <= '0;
         ovf_q   <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         fill_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (anyReq) begin
                  ptr_q   <= ptr_d;
                  id_q    <= winner;
                  work_q  <= capData;
                  ovf_q   <= '0;
                  rem_q   <= capAmt;
                  dir_q   <= capDir;
                  fill_q  <= capFill;
                  state_q <= (capAmt == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               work_q <= bus.sh_out_packed;
               ovf_q  <= ovf_q | bus.sh_overflow_packed;
               rem_q  <= rem_d;
               if (rem_d == '0) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef SHIFT_SEQ_STATS_EN
   logic [15:0] ops_done_q;

   // Count completed response transfers, wrapping naturally at 16 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         ops_done_q <= '0;
      end else if ((state_q == DONE) && bus.rsp_ready) begin
         ops_done_q <= ops_done_q + 16'd1;
      end
   end

   assign ops_done = ops_done_q;
`endif

endmodule
